// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / instruction-fetch stage.
package pc_pkg;

  localparam int          DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

  // Canonical RISC-V no-op (addi x0, x0, 0), available to consumers that need a filler word
  localparam logic [31:0] NOP_INST      = 32'h0000_0013;

  // Which redirect source won arbitration this cycle
  typedef enum logic [1:0] {
    RD_NONE,
    RD_BR,
    RD_JMP,
    RD_TRAP
  } rd_src_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry output buffer (output register plus skid) between the ROM response and decode.
// Incoming data lands in the output register when it is empty or being consumed, otherwise
// in the skid; the skid always drains first so program order is preserved.
module fetch_skid_buf #(
  parameter int DW = 96
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          skid_valid
);

  logic [DW-1:0] skid_data;
  logic          drain;

  assign drain = !out_valid || out_ready;

  // Output register and skid entry update; flush discards everything still buffered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        if (in_valid) begin
          skid_data <= in_data;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (in_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: drives a 1-cycle synchronous ROM, arbitrates
// trap/jump/branch redirects and hands {pc, pc+4, inst} to decode through a 2-entry buffer.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int               XLEN      = DEF_XLEN,
  parameter int               IMEM_AW   = 6,
  parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0]  TRAP_VEC  = XLEN'(DEF_TRAP_VEC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trap,
  input  logic               jmp_valid,
  input  logic [XLEN-1:0]    jmp_target,
  input  logic               br_taken,
  input  logic [XLEN-1:0]    br_base,
  input  logic [XLEN-1:0]    br_offset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_pc4,
  output logic [31:0]        if_inst,
  output logic               misalign
);

  localparam int PW = 2 * XLEN + 32;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            req_v;
  logic [XLEN-1:0] rd_target;
  rd_src_e         rd_src;
  logic            redirect;
  logic            issue_en;
  logic            skid_v;
  logic [PW-1:0]   rsp_data;
  logic [PW-1:0]   out_data;

  // Upper PC bits beyond the ROM size simply alias onto the same words
  assign imem_addr = pc[IMEM_AW+1:2];

  // Stop issuing when both buffer slots could end up occupied
  assign issue_en = !skid_v && !(if_valid && !if_ready && req_v);

  // Redirect arbitration: trap beats jump beats branch
  always_comb begin
    rd_src    = RD_NONE;
    rd_target = '0;
    if (trap) begin
      rd_src    = RD_TRAP;
      rd_target = TRAP_VEC;
    end else if (jmp_valid) begin
      rd_src    = RD_JMP;
      rd_target = jmp_target;
    end else if (br_taken) begin
      rd_src    = RD_BR;
      rd_target = br_base + br_offset;
    end
  end

  assign redirect = (rd_src != RD_NONE);

  // PC register and outstanding-request tracking; a redirect overrides any stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_VEC;
      req_pc   <= RESET_VEC;
      req_v    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (redirect) begin
        pc       <= {rd_target[XLEN-1:2], 2'b00};
        req_v    <= 1'b0;
        misalign <= |rd_target[1:0];
      end else if (issue_en) begin
        pc     <= pc + XLEN'(4);
        req_pc <= pc;
        req_v  <= 1'b1;
      end else begin
        req_v <= 1'b0;
      end
    end
  end

  assign rsp_data = {req_pc, req_pc + XLEN'(4), imem_rdata};

  fetch_skid_buf #(
    .DW (PW)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .in_valid   (req_v),
    .in_data    (rsp_data),
    .out_valid  (if_valid),
    .out_ready  (if_ready),
    .out_data   (out_data),
    .skid_valid (skid_v)
  );

  assign {if_pc, if_pc4, if_inst} = out_data;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with a 64-word synchronous ROM where ROM[i] = i.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        trap;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        br_taken;
  logic [31:0] br_base;
  logic [31:0] br_offset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        misalign;

  int tests_run;
  int tests_failed;

  pc_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .trap       (trap),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_base    (br_base),
    .br_offset  (br_offset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4),
    .if_inst    (if_inst),
    .misalign   (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM model: one-cycle read latency, contents equal to the word index
  always_ff @(posedge clk) begin
    imem_rdata <= {26'd0, imem_addr};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    check_bit("reset_if_valid", if_valid, 1'b0);
    check_bit("reset_misalign", misalign, 1'b0);
    check_word("reset_if_pc", if_pc, 32'h0);
    check_word("reset_if_inst", if_inst, 32'h0);
    check_word("reset_imem_addr", {26'd0, imem_addr}, 32'h0);
    reset = 1'b0;
    step();
    check_bit("edge1_if_valid", if_valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_bit("stream_if_valid", if_valid, 1'b1);
      check_word("stream_if_pc", if_pc, 32'(4 * k));
      check_word("stream_if_pc4", if_pc4, 32'(4 * k + 4));
      check_word("stream_if_inst", if_inst, 32'(k));
    end
  endtask

  task automatic test_stall();
    int got_n;
    int cyc;
    logic [31:0] seen_pc [6];
    logic [31:0] seen_inst [6];
    if_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      check_bit("stall_if_valid", if_valid, 1'b1);
      check_word("stall_if_pc", if_pc, 32'h10);
      check_word("stall_if_pc4", if_pc4, 32'h14);
      check_word("stall_if_inst", if_inst, 32'h4);
      check_word("stall_imem_addr", {26'd0, imem_addr}, 32'h6);
    end
    if_ready = 1'b1;
    got_n = 0;
    cyc = 0;
    while (got_n < 6 && cyc < 30) begin
      if (if_valid) begin
        seen_pc[got_n]   = if_pc;
        seen_inst[got_n] = if_inst;
        got_n++;
      end
      step();
      cyc++;
    end
    tests_run++;
    if (got_n != 6) begin
      tests_failed++;
      $display("[TB] FAIL stall_release_timeout: got %0d insts expected 6", got_n);
    end
    for (int n = 0; n < got_n; n++) begin
      check_word("release_pc", seen_pc[n], 32'(16 + 4 * n));
      check_word("release_inst", seen_inst[n], 32'(4 + n));
    end
  endtask

  task automatic test_branch();
    br_taken  = 1'b1;
    br_base   = 32'h10;
    br_offset = 32'hFFFF_FFF8;
    step();
    br_taken = 1'b0;
    check_bit("br_t1_if_valid", if_valid, 1'b0);
    check_bit("br_t1_misalign", misalign, 1'b0);
    check_word("br_t1_imem_addr", {26'd0, imem_addr}, 32'h2);
    step();
    check_bit("br_t2_if_valid", if_valid, 1'b0);
    step();
    check_bit("br_t3_if_valid", if_valid, 1'b1);
    check_word("br_t3_if_pc", if_pc, 32'h8);
    check_word("br_t3_if_inst", if_inst, 32'h2);
    step();
    check_word("br_t4_if_pc", if_pc, 32'hC);
  endtask

  task automatic test_priority();
    trap       = 1'b1;
    jmp_valid  = 1'b1;
    jmp_target = 32'h40;
    br_taken   = 1'b1;
    br_base    = 32'h100;
    br_offset  = 32'h4;
    step();
    trap      = 1'b0;
    jmp_valid = 1'b0;
    br_taken  = 1'b0;
    check_bit("prio_t1_if_valid", if_valid, 1'b0);
    step();
    step();
    check_bit("prio_t3_if_valid", if_valid, 1'b1);
    check_word("prio_t3_if_pc", if_pc, 32'h80);
    check_word("prio_t3_if_inst", if_inst, 32'h20);
    step();
    check_word("prio_t4_if_pc", if_pc, 32'h84);
    check_word("prio_t4_if_inst", if_inst, 32'h21);
  endtask

  task automatic test_misalign();
    jmp_valid  = 1'b1;
    jmp_target = 32'h22;
    step();
    jmp_valid = 1'b0;
    check_bit("mis_t1_pulse", misalign, 1'b1);
    step();
    check_bit("mis_t2_clear", misalign, 1'b0);
    step();
    check_bit("mis_t3_if_valid", if_valid, 1'b1);
    check_word("mis_t3_if_pc", if_pc, 32'h20);
    check_word("mis_t3_if_inst", if_inst, 32'h8);
    check_bit("mis_t3_misalign", misalign, 1'b0);
  endtask

  task automatic test_wrap_and_reset();
    jmp_valid  = 1'b1;
    jmp_target = 32'hFFFF_FFF8;
    step();
    jmp_valid = 1'b0;
    step();
    step();
    check_word("wrap_pc_fff8", if_pc, 32'hFFFF_FFF8);
    check_word("wrap_inst_fff8", if_inst, 32'd62);
    step();
    check_word("wrap_pc_fffc", if_pc, 32'hFFFF_FFFC);
    check_word("wrap_pc4_fffc", if_pc4, 32'h0);
    check_word("wrap_inst_fffc", if_inst, 32'd63);
    step();
    check_word("wrap_pc_zero", if_pc, 32'h0);
    check_word("wrap_inst_zero", if_inst, 32'h0);
    if_ready = 1'b0;
    step();
    step();
    check_bit("pre_reset_if_valid", if_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_bit("async_reset_if_valid", if_valid, 1'b0);
    check_word("async_reset_if_pc", if_pc, 32'h0);
    check_word("async_reset_imem_addr", {26'd0, imem_addr}, 32'h0);
    if_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    check_bit("refetch_e1_if_valid", if_valid, 1'b0);
    step();
    check_bit("refetch_e2_if_valid", if_valid, 1'b1);
    check_word("refetch_e2_if_pc", if_pc, 32'h0);
    step();
    check_word("refetch_e3_if_pc", if_pc, 32'h4);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    trap         = 1'b0;
    jmp_valid    = 1'b0;
    jmp_target   = '0;
    br_taken     = 1'b0;
    br_base      = '0;
    br_offset    = '0;
    if_ready     = 1'b1;
    test_reset();
    test_stall();
    test_branch();
    test_priority();
    test_misalign();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
